// File: rtl/sponge_padder.sv
// Collects message words into a RATE_BITS block and appends sponge padding
// (domain byte, zero fill, end byte) after the last word of a message.
module sponge_padder #(
  parameter int unsigned IN_WIDTH    = 8,
  parameter int unsigned RATE_BITS   = 256,
  parameter logic [7:0]  DOMAIN_BYTE = 8'h1f,
  parameter logic [7:0]  END_BYTE    = 8'h80
) (
  input  logic                 clk_i,
  input  logic                 clear_i,
  input  logic [IN_WIDTH-1:0]  in_data_i,
  input  logic                 in_valid_i,
  input  logic                 in_last_i,
  output logic                 in_ready_o,
  output logic [RATE_BITS-1:0] block_out_o,
  output logic                 block_valid_o,
  output logic                 block_last_o,
  input  logic                 block_ready_i
);

  localparam int unsigned P    = RATE_BITS / IN_WIDTH;
  localparam int unsigned CntW = $clog2(P);
  localparam logic [CntW-1:0] CntMax = CntW'(P - 1);

  typedef enum logic [1:0] {StAbsorb, StPad, StFull} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic                 pad_pending_q, pad_pending_d;
  logic                 first_pad_q, first_pad_d;
  logic                 last_q, last_d;
  logic [RATE_BITS-1:0] slots_q, slots_d;
  logic [IN_WIDTH-1:0]  pad_word;

  assign cnt_inc = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;

  // With 8-bit words the domain and end bytes share the same byte when they collide.
  always_comb begin
    pad_word = '0;
    if (first_pad_q) pad_word[7:0] = DOMAIN_BYTE;
    if (cnt_q == CntMax) pad_word[IN_WIDTH-1 -: 8] = pad_word[IN_WIDTH-1 -: 8] | END_BYTE;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pad_pending_d = pad_pending_q;
    first_pad_d   = first_pad_q;
    last_d        = last_q;
    slots_d       = slots_q;
    case (state_q)
      StAbsorb: begin
        if (in_valid_i) begin
          slots_d[cnt_q*IN_WIDTH +: IN_WIDTH] = in_data_i;
          cnt_d = cnt_inc;
          if (cnt_q == CntMax) begin
            // A last word that fills the block needs a whole extra padding block.
            state_d       = StFull;
            last_d        = 1'b0;
            pad_pending_d = in_last_i;
          end else if (in_last_i) begin
            state_d     = StPad;
            first_pad_d = 1'b1;
          end
        end
      end
      StPad: begin
        slots_d[cnt_q*IN_WIDTH +: IN_WIDTH] = pad_word;
        cnt_d       = cnt_inc;
        first_pad_d = 1'b0;
        if (cnt_q == CntMax) begin
          state_d       = StFull;
          last_d        = 1'b1;
          pad_pending_d = 1'b0;
        end
      end
      StFull: begin
        if (block_ready_i) begin
          slots_d = '0;
          cnt_d   = '0;
          last_d  = 1'b0;
          if (pad_pending_q) begin
            state_d     = StPad;
            first_pad_d = 1'b1;
          end else begin
            state_d = StAbsorb;
          end
        end
      end
      default: state_d = StAbsorb;
    endcase
  end

  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      state_q       <= StAbsorb;
      cnt_q         <= '0;
      pad_pending_q <= 1'b0;
      first_pad_q   <= 1'b0;
      last_q        <= 1'b0;
      slots_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pad_pending_q <= pad_pending_d;
      first_pad_q   <= first_pad_d;
      last_q        <= last_d;
      slots_q       <= slots_d;
    end
  end

  assign in_ready_o    = (state_q == StAbsorb);
  assign block_valid_o = (state_q == StFull);
  assign block_out_o   = slots_q;
  assign block_last_o  = last_q;

endmodule
